bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master data-bus arbiter: round-robin grants when idle, locked bursts
// capped at MAX_BURST beats while the other master is waiting.
module bus_arbiter #(
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned RESET_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_lock,
    input  logic        m1_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wr_data,
    input  logic [31:0] m1_wr_data,
    input  logic [3:0]  m0_wr_en,
    input  logic [3:0]  m1_wr_en,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic [31:0] m0_rd_data,
    output logic [31:0] m1_rd_data,
    output logic        m0_rd_valid,
    output logic        m1_rd_valid,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wr_data,
    output logic [3:0]  bus_wr_en,
    input  logic [31:0] bus_rd_data,
    output logic [1:0]  owner
);

    localparam int unsigned CW       = $clog2(MAX_BURST + 1);
    localparam bit          ONE_BEAT = (MAX_BURST <= 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_rd_valid0;
    logic          r_rd_valid1;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any;
    logic          w_sel;
    logic          w_lock;
    logic          w_other_req;
    logic          w_both_req;
    logic [CW-1:0] w_cnt_inc;
    logic          w_at_max;

    // Grant decision, same cycle as the request
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        w_gnt0 = ~r_ptr;
                        w_gnt1 = r_ptr;
                    end else begin
                        w_gnt0 = m0_req;
                        w_gnt1 = m1_req;
                    end
                end
                LOCK0:   w_gnt0 = m0_req;
                LOCK1:   w_gnt1 = m1_req;
                default: ;
            endcase
        end
    end

    assign w_any       = w_gnt0 | w_gnt1;
    assign w_sel       = w_gnt1;
    assign w_lock      = w_gnt1 ? m1_lock : m0_lock;
    assign w_other_req = w_gnt1 ? m0_req : m1_req;
    assign w_both_req  = m0_req & m1_req;
    assign w_cnt_inc   = (r_cnt >= CW'(MAX_BURST)) ? CW'(MAX_BURST) : r_cnt + CW'(1);
    assign w_at_max    = (w_cnt_inc == CW'(MAX_BURST));

    // Shared bus driven by the granted master, zero when nobody is granted
    always_comb begin
        bus_addr    = 32'd0;
        bus_wr_data = 32'd0;
        bus_wr_en   = 4'd0;
        if (w_gnt0) begin
            bus_addr    = m0_addr;
            bus_wr_data = m0_wr_data;
            bus_wr_en   = m0_wr_en;
        end else if (w_gnt1) begin
            bus_addr    = m1_addr;
            bus_wr_data = m1_wr_data;
            bus_wr_en   = m1_wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= 1'(RESET_PRIORITY);
            r_cnt       <= '0;
            r_rd_valid0 <= 1'b0;
            r_rd_valid1 <= 1'b0;
        end else begin
            r_rd_valid0 <= w_gnt0 && (m0_wr_en == 4'd0);
            r_rd_valid1 <= w_gnt1 && (m1_wr_en == 4'd0);
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        if (w_both_req) begin
                            r_ptr <= ~w_sel;
                        end
                        if (w_lock) begin
                            if (ONE_BEAT && w_other_req) begin
                                r_ptr <= ~w_sel;
                            end else begin
                                r_state <= w_sel ? LOCK1 : LOCK0;
                                r_cnt   <= CW'(1);
                            end
                        end
                    end
                end
                LOCK0, LOCK1: begin
                    if (!w_any || !w_lock) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_at_max && w_other_req) begin
                        // Burst cap reached with the other master waiting: hand over
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_ptr   <= ~w_sel;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign m0_gnt      = w_gnt0;
    assign m1_gnt      = w_gnt1;
    assign m0_rd_data  = bus_rd_data;
    assign m1_rd_data  = bus_rd_data;
    assign m0_rd_valid = r_rd_valid0;
    assign m1_rd_valid = r_rd_valid1;
    assign owner       = r_state;

    // Protocol properties: exclusive grants, quiet bus, read-only valids, master hold
    a_one_gnt: assert property (@(posedge clk) disable iff (reset)
        !(m0_gnt && m1_gnt));
    a_quiet_bus: assert property (@(posedge clk) disable iff (reset)
        !(m0_gnt || m1_gnt) |-> (bus_wr_en == 4'd0));
    a_rv0_read: assert property (@(posedge clk) disable iff (reset)
        m0_rd_valid |-> $past(m0_gnt && (m0_wr_en == 4'd0)));
    a_rv1_read: assert property (@(posedge clk) disable iff (reset)
        m1_rd_valid |-> $past(m1_gnt && (m1_wr_en == 4'd0)));
    a_m0_hold: assert property (@(posedge clk) disable iff (reset)
        (m0_req && !m0_gnt) |=> (m0_req && $stable(m0_addr) &&
                                 $stable(m0_wr_data) && $stable(m0_wr_en)));
    a_m1_hold: assert property (@(posedge clk) disable iff (reset)
        (m1_req && !m1_gnt) |=> (m1_req && $stable(m1_addr) &&
                                 $stable(m1_wr_data) && $stable(m1_wr_en)));

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural ownership model.
module tb_bus_arbiter;

    localparam int MB = 16;
    localparam int RP = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_lock, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wr_data, m1_wr_data;
    logic [3:0]  m0_wr_en, m1_wr_en;
    logic        m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid;
    logic [31:0] m0_rd_data, m1_rd_data;
    logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
    logic [3:0]  bus_wr_en;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_errors = 0;

    // Model: who owns the bus (0 none, 1 m0, 2 m1), whose turn it is, beats held
    int m_state, m_ptr, m_cnt, m_g;
    bit m_rv0, m_rv1;

    bus_arbiter #(.MAX_BURST(MB), .RESET_PRIORITY(RP)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data),
        .m0_wr_en(m0_wr_en), .m1_wr_en(m1_wr_en),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rd_data(m0_rd_data), .m1_rd_data(m1_rd_data),
        .m0_rd_valid(m0_rd_valid), .m1_rd_valid(m1_rd_valid),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_wr_en(bus_wr_en),
        .bus_rd_data(bus_rd_data), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int calc_grant();
        if (reset) return -1;
        if (m_state == 0) begin
            if (m0_req && m1_req) return m_ptr;
            if (m0_req) return 0;
            if (m1_req) return 1;
            return -1;
        end
        if (m_state == 1) return m0_req ? 0 : -1;
        return m1_req ? 1 : -1;
    endfunction

    // Compare every observable output against the model, mid-cycle
    task automatic cyc_check();
        logic [31:0] ea, ed;
        logic [3:0]  ew;
        @(negedge clk);
        m_g = calc_grant();
        ea = (m_g == 0) ? m0_addr    : (m_g == 1) ? m1_addr    : 32'd0;
        ed = (m_g == 0) ? m0_wr_data : (m_g == 1) ? m1_wr_data : 32'd0;
        ew = (m_g == 0) ? m0_wr_en   : (m_g == 1) ? m1_wr_en   : 4'd0;
        check("m0_gnt", 32'(m0_gnt), 32'(m_g == 0));
        check("m1_gnt", 32'(m1_gnt), 32'(m_g == 1));
        check("bus_addr", bus_addr, ea);
        check("bus_wr_data", bus_wr_data, ed);
        check("bus_wr_en", 32'(bus_wr_en), 32'(ew));
        check("owner", 32'(owner), 32'(m_state));
        check("m0_rd_valid", 32'(m0_rd_valid), 32'(m_rv0));
        check("m1_rd_valid", 32'(m1_rd_valid), 32'(m_rv1));
        check("m0_rd_data", m0_rd_data, bus_rd_data);
        check("m1_rd_data", m1_rd_data, bus_rd_data);
    endtask

    // Advance one clock and apply the ownership rules to the model
    task automatic cyc_adv();
        bit other, lk;
        @(posedge clk);
        if (reset) begin
            m_state = 0; m_ptr = RP; m_cnt = 0; m_rv0 = 0; m_rv1 = 0;
        end else begin
            m_rv0 = (m_g == 0) && (m0_wr_en == 4'd0);
            m_rv1 = (m_g == 1) && (m1_wr_en == 4'd0);
            if (m_g < 0) begin
                m_state = 0;
            end else begin
                other = (m_g == 0) ? m1_req : m0_req;
                lk    = (m_g == 0) ? m0_lock : m1_lock;
                if (m_state == 0) begin
                    if (m0_req && m1_req) m_ptr = 1 - m_g;
                    if (lk) begin
                        m_state = m_g + 1;
                        m_cnt   = 1;
                    end
                end else begin
                    m_cnt = (m_cnt + 1 > MB) ? MB : m_cnt + 1;
                    if (!lk) m_state = 0;
                end
                if (m_state != 0 && m_cnt >= MB && other) begin
                    m_state = 0;
                    m_ptr   = 1 - m_g;
                end
            end
            if (m_state == 0) m_cnt = 0;
        end
        #1;
        bus_rd_data = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
        m0_wr_en = 4'd0; m1_wr_en = 4'd0;
        repeat (2) begin cyc_check(); cyc_adv(); end
        reset = 1'b0;
    endtask

    task automatic rand_master(input bit hold, output logic req, output logic lk,
                               output logic [31:0] a, output logic [31:0] d,
                               output logic [3:0] we, input logic [31:0] a_i,
                               input logic [31:0] d_i, input logic [3:0] we_i);
        if (hold) begin
            req = 1'b1; a = a_i; d = d_i; we = we_i;
        end else begin
            req = ($urandom_range(0, 3) != 0);
            a   = $urandom;
            d   = $urandom;
            we  = $urandom_range(0, 1) ? 4'($urandom) : 4'd0;
        end
        lk = ($urandom_range(0, 5) != 0);
    endtask

    initial begin
        bit          h0, h1;
        logic        q, l;
        logic [31:0] a, d;
        logic [3:0]  w;

        bus_rd_data = 32'h0; m0_addr = 0; m1_addr = 0; m0_wr_data = 0; m1_wr_data = 0;
        do_reset();
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_rv0", 32'(m0_rd_valid), 32'd0);

        // Single write from m0 while m1 is idle
        m0_req = 1; m0_addr = 32'hC000_1000; m0_wr_data = 32'h1234_5678; m0_wr_en = 4'hF;
        cyc_check();
        check("wr_gnt", 32'(m0_gnt), 32'd1);
        check("wr_addr", bus_addr, 32'hC000_1000);
        check("wr_data", bus_wr_data, 32'h1234_5678);
        check("wr_en", 32'(bus_wr_en), 32'hF);
        cyc_adv();
        m0_req = 0;
        cyc_check();
        check("wr_no_rv", 32'(m0_rd_valid), 32'd0);
        cyc_adv();

        // Both masters reading continuously alternate, starting with m0
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 32'h100; m1_addr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            cyc_check();
            check("alt_g0", 32'(m0_gnt), 32'(i % 2 == 0));
            if (i > 0) check("alt_rv1", 32'(m1_rd_valid), 32'(i % 2 == 0));
            cyc_adv();
        end

        // m1 locks a 4-beat burst while m0 waits
        do_reset();
        m1_req = 1; m1_lock = 1; m1_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            m1_lock = (i < 3);
            cyc_check();
            check("b4_g1", 32'(m1_gnt), 32'd1);
            if (i > 0) check("b4_owner", 32'(owner), 32'd2);
            cyc_adv();
            m0_req = 1; m0_addr = 32'h400;
        end
        m1_req = 0;
        cyc_check();
        check("b4_g0_after", 32'(m0_gnt), 32'd1);
        cyc_adv();

        // m0 holds lock forever with m1 waiting: capped at MB beats
        do_reset();
        m0_req = 1; m0_lock = 1; m1_req = 1; m1_lock = 0; m1_addr = 32'h500;
        for (int i = 0; i < MB; i++) begin
            cyc_check();
            check("cap_g0", 32'(m0_gnt), 32'd1);
            cyc_adv();
        end
        cyc_check();
        check("cap_g1", 32'(m1_gnt), 32'd1);
        check("cap_idle", 32'(owner), 32'd0);
        cyc_adv();
        cyc_check();
        check("cap_ptr_back", 32'(m0_gnt), 32'd1);
        cyc_adv();

        // Reset in the middle of an m1 burst abandons the lock
        do_reset();
        m1_req = 1; m1_lock = 1; m1_addr = 32'h600;
        repeat (2) begin cyc_check(); cyc_adv(); end
        reset = 1;
        cyc_check();
        check("mid_rst_g1", 32'(m1_gnt), 32'd0);
        cyc_adv();
        cyc_check();
        check("mid_rst_owner", 32'(owner), 32'd0);
        check("mid_rst_nog", 32'({m0_gnt, m1_gnt}), 32'd0);
        cyc_adv();
        reset = 0; m0_req = 1; m0_lock = 0; m1_lock = 0; m0_addr = 32'h700;
        cyc_check();
        check("post_rst_g0", 32'(m0_gnt), 32'd1);
        cyc_adv();

        // Random traffic; ungranted requesters hold their beat
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            h0 = m0_req && (m_g != 0) && !reset;
            h1 = m1_req && (m_g != 1) && !reset;
            reset = ($urandom_range(0, 299) == 0);
            rand_master(h0, q, l, a, d, w, m0_addr, m0_wr_data, m0_wr_en);
            m0_req = q; m0_lock = l; m0_addr = a; m0_wr_data = d; m0_wr_en = w;
            rand_master(h1, q, l, a, d, w, m1_addr, m1_wr_data, m1_wr_en);
            m1_req = q; m1_lock = l; m1_addr = a; m1_wr_data = d; m1_wr_en = w;
            cyc_check();
            cyc_adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
